// File: rtl/seven_seg_scan.sv
// Four-digit hex scanner for the Basys3 seven-segment display.
// Latches a 16-bit value on Update and drives active-low anodes/segments with a dark guard at each slot start.
module seven_seg_scan #(
   parameter int REFRESH_DIV   = 100000,
   parameter int GUARD         = 16,
   parameter int BLANK_LEADING = 0
) (
   input  logic        BasysCLK,
   input  logic        Reset_n,
   input  logic        Update,
   input  logic [15:0] Value,
   input  logic [3:0]  DP_in,
   input  logic        Enable,
   output logic [3:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic        FrameTick
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_END = CW'(GUARD);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   shadow_val;
   logic [3:0]    shadow_dp;

   logic [3:0] digit;
   logic [3:0] lead_zero;
   logic [6:0] hex_seg;
   logic       dark;
   logic       blank;
   logic [3:0] an_next;
   logic [6:0] seg_next;
   logic       dp_next;

   always_ff @(posedge BasysCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         cnt        <= '0;
         idx        <= '0;
         AN         <= 4'b1111;
         SEG        <= 7'h7F;
         DP         <= 1'b1;
         FrameTick  <= 1'b0;
      end else begin
         if (Update) begin
            shadow_val <= Value;
            shadow_dp  <= DP_in;
         end
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         FrameTick <= (cnt == CNT_LAST) && (idx == 2'd3);
         AN        <= an_next;
         SEG       <= seg_next;
         DP        <= dp_next;
      end
   end

   // lead_zero[k]: digits k..3 are all zero; digit 0 is never blanked.
   always_comb begin
      lead_zero    = 4'b0000;
      lead_zero[3] = (shadow_val[15:12] == 4'h0);
      lead_zero[2] = lead_zero[3] && (shadow_val[11:8] == 4'h0);
      lead_zero[1] = lead_zero[2] && (shadow_val[7:4] == 4'h0);
   end

   always_comb begin
      digit = shadow_val[{idx, 2'b00} +: 4];
      case (digit)
         4'h0: hex_seg = 7'b1000000;
         4'h1: hex_seg = 7'b1111001;
         4'h2: hex_seg = 7'b0100100;
         4'h3: hex_seg = 7'b0110000;
         4'h4: hex_seg = 7'b0011001;
         4'h5: hex_seg = 7'b0010010;
         4'h6: hex_seg = 7'b0000010;
         4'h7: hex_seg = 7'b1111000;
         4'h8: hex_seg = 7'b0000000;
         4'h9: hex_seg = 7'b0010000;
         4'hA: hex_seg = 7'b0001000;
         4'hB: hex_seg = 7'b0000011;
         4'hC: hex_seg = 7'b1000110;
         4'hD: hex_seg = 7'b0100001;
         4'hE: hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   end

   // The guard keeps all anodes off while idx changes, so two digits never overlap.
   always_comb begin
      an_next  = 4'b1111;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      dark     = (cnt < GUARD_END) || !Enable;
      blank    = (BLANK_LEADING != 0) && lead_zero[idx];
      if (!dark) begin
         an_next  = ~(4'b0001 << idx);
         seg_next = blank ? 7'h7F : hex_seg;
         dp_next  = ~shadow_dp[idx];
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan (REFRESH_DIV=8, GUARD=2): a positional model keyed to edges since reset
// pushes expected pins each edge; a negedge checker pops and compares for both blanking settings.
module tb_seven_seg_scan;

   typedef struct packed {
      logic [15:0]     value;
      logic [3:0]      dp;
      logic [3:0][6:0] seg_nb;  // BLANK_LEADING=0, index = digit
      logic [3:0][6:0] seg_b;   // BLANK_LEADING=1
   } vec_t;

   localparam int NVEC = 7;

   logic        clk;
   logic        rst_n;
   logic        upd;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        en;
   logic [3:0]  an0, an1;
   logic [6:0]  seg0, seg1;
   logic        dp0, dp1, ft0, ft1;

   vec_t tbl [NVEC];
   int   drv_sel;
   int   shadow_sel;
   int   cyc;
   int   checks;
   int   errors;

   // {an, seg_nb, seg_b, dp, frame_tick}
   logic [19:0] exp_q[$];

   seven_seg_scan #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LEADING(0)) dut (
      .BasysCLK(clk), .Reset_n(rst_n), .Update(upd), .Value(value), .DP_in(dp_in),
      .Enable(en), .AN(an0), .SEG(seg0), .DP(dp0), .FrameTick(ft0)
   );

   seven_seg_scan #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LEADING(1)) dut_bl (
      .BasysCLK(clk), .Reset_n(rst_n), .Update(upd), .Value(value), .DP_in(dp_in),
      .Enable(en), .AN(an1), .SEG(seg1), .DP(dp1), .FrameTick(ft1)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected pins for the edge about to happen, from position since reset release.
   always @(posedge clk) begin
      int q, s, r;
      logic [3:0] an_e;
      logic [6:0] sn_e, sb_e;
      logic       dp_e, ft_e;
      if (!rst_n) begin
         cyc = 0;
         shadow_sel = 0;
         exp_q.delete();
      end else begin
         q = cyc % 32;
         s = q / 8;
         r = q % 8;
         an_e = 4'b1111;
         sn_e = 7'h7F;
         sb_e = 7'h7F;
         dp_e = 1'b1;
         if (r >= 2 && en) begin
            an_e[s] = 1'b0;
            sn_e = tbl[shadow_sel].seg_nb[s];
            sb_e = tbl[shadow_sel].seg_b[s];
            dp_e = ~tbl[shadow_sel].dp[s];
         end
         ft_e = (q == 31);
         exp_q.push_back({an_e, sn_e, sb_e, dp_e, ft_e});
         if (upd) shadow_sel = drv_sel;
         cyc++;
      end
   end

   // scoreboard checker
   always @(negedge clk) begin
      logic [19:0] e;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("an", {28'd0, an0}, {28'd0, e[19:16]});
         check("an_bl", {28'd0, an1}, {28'd0, e[19:16]});
         check("seg", {25'd0, seg0}, {25'd0, e[15:9]});
         check("seg_bl", {25'd0, seg1}, {25'd0, e[8:2]});
         check("dp", {30'd0, dp1, dp0}, {30'd0, e[1], e[1]});
         check("frame_tick", {30'd0, ft1, ft0}, {30'd0, e[0], e[0]});
         check("one_anode", {31'd0, ($countones(~an0) <= 1)}, 32'd1);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load(input int i);
      drv_sel = i;
      value   = tbl[i].value;
      dp_in   = tbl[i].dp;
      upd     = 1'b1;
      step();
      upd     = 1'b0;
   endtask

   task automatic dark_now(input string name);
      check({name, "_an"}, {24'd0, an1, an0}, {24'd0, 8'hFF});
      check({name, "_seg"}, {18'd0, seg1, seg0}, {18'd0, 14'h3FFF});
      check({name, "_dp_ft"}, {28'd0, dp1, dp0, ft1, ft0}, {28'd0, 4'b1100});
   endtask

   initial begin
      // digit order in the segment fields: {d3, d2, d1, d0}
      tbl[0] = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      tbl[1] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
      tbl[2] = '{16'h0007, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
      tbl[3] = '{16'hABCD, 4'b0101, {7'h08, 7'h03, 7'h46, 7'h21}, {7'h08, 7'h03, 7'h46, 7'h21}};
      tbl[4] = '{16'h0F00, 4'b1000, {7'h40, 7'h0E, 7'h40, 7'h40}, {7'h7F, 7'h0E, 7'h40, 7'h40}};
      tbl[5] = '{16'h5E69, 4'b1111, {7'h12, 7'h06, 7'h02, 7'h10}, {7'h12, 7'h06, 7'h02, 7'h10}};
      tbl[6] = '{16'h0080, 4'b0000, {7'h40, 7'h40, 7'h00, 7'h40}, {7'h7F, 7'h7F, 7'h00, 7'h40}};

      checks  = 0;
      errors  = 0;
      cyc     = 0;
      drv_sel = 0;
      shadow_sel = 0;
      rst_n   = 1'b0;
      upd     = 1'b0;
      value   = 16'h0;
      dp_in   = 4'h0;
      en      = 1'b1;

      run(3);
      dark_now("reset_init");
      rst_n = 1'b1;

      // zeros after reset, then every table vector over a full frame
      run(36);
      for (int i = 0; i < NVEC; i++) begin
         load(i);
         run(36 + $urandom_range(0, 7));
      end

      // update landing on the digit 0->1 wrap edge
      load(1);
      run(5);
      for (int k = 0; k < 40 && (cyc % 32) != 7; k++) step();
      check("wrap_align", cyc % 32, 7);
      load(3);
      run(40);

      // display disabled for 20 cycles mid-frame
      run(13);
      en = 1'b0;
      run(20);
      en = 1'b1;
      run(40);

      // Update held high: re-captured every cycle
      drv_sel = 4; value = tbl[4].value; dp_in = tbl[4].dp; upd = 1'b1;
      for (int i = 5; i < NVEC; i++) begin
         step();
         drv_sel = i; value = tbl[i].value; dp_in = tbl[i].dp;
      end
      step();
      upd = 1'b0;
      run(40);

      // async reset mid-slot, then 4-frame run from a nonzero value
      load(5);
      run(19);
      rst_n = 1'b0;
      #1;
      dark_now("reset_async");
      run(2);
      rst_n = 1'b1;
      run(10);
      load(6);
      run(128);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
